// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered reads.
// Same-edge writes are forwarded to a matching enabled read.
module regfile_2r1w #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic              wvalid;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // A write to r0 is dropped when r0 is hardwired.
  assign wvalid = we && !(ZERO_R0 && (waddr == '0));

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (ZERO_R0 && (i == 0)) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_ff
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem[i] <= RST_VAL;
        end else if (wvalid && (waddr == ADDR_W'(i))) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rd_a = mem[raddr_a];
    rd_b = mem[raddr_b];
    if (wvalid && (waddr == raddr_a)) begin
      rd_a = wdata;
    end
    if (wvalid && (waddr == raddr_b)) begin
      rd_b = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= RST_VAL;
      rdata_b <= RST_VAL;
    end else begin
      if (re_a) begin
        rdata_a <= rd_a;
      end
      if (re_b) begin
        rdata_b <= rd_b;
      end
    end
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Register file for the 3-stage processor: one write port fed by the writeback stage and two read ports feeding the execute stage's operand latches. Storage is enable-gated flip-flops, the same element style as the pipeline's single-bit state cells. Reads are registered, with one cycle of latency. A same-cycle write to the register being read is forwarded, so the pipeline needs no extra read-after-write bypass for the regfile.

## Interface
Parameters:
- DATA_W, 8, width of each register and of every data port
- ADDR_W, 3, address width; the file holds 2**ADDR_W registers
- RST_VAL, 0, value loaded into every register and both read outputs on reset
- ZERO_R0, 1, when 1, register 0 reads as 0 and writes to it are discarded

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- re_a  in  1  read enable, port A
- raddr_a  in  ADDR_W  read address, port A
- rdata_a  out  DATA_W  registered read data, port A
- re_b  in  1  read enable, port B
- raddr_b  in  ADDR_W  read address, port B
- rdata_b  out  DATA_W  registered read data, port B

## Operation
Reset:
- rst_n low, at any time and independent of clk: every register, rdata_a and rdata_b are forced to RST_VAL.
- Exception: register 0 reads as 0 when ZERO_R0=1.
- Reset asserted mid-operation discards any write or read in flight that edge.

Write:
- On a rising edge with we=1, register[waddr] is loaded with wdata.
- With ZERO_R0=1 and waddr=0, the write is discarded.
- With we=0, all registers hold.

Read, port A (port B is identical and independent):
- On a rising edge with re_a=1, rdata_a is loaded with the value of register[raddr_a].
- With re_a=0, rdata_a holds its previous value.

Forwarding:
- On an edge where re_a=1, we=1, raddr_a==waddr and the write is not discarded, rdata_a loads wdata, not the old contents.
- The same rule applies to port B.

Simultaneous events:
- Both ports may read the same address; both see the same value, forwarded if applicable.
- Read addresses equal to each other and to waddr: both ports get wdata.
- Write to register 0 with ZERO_R0=1 while a port reads register 0: that port gets 0.

Arithmetic and widths:
- No arithmetic is performed.
- Addresses are used as-is; every address value is valid, so there is no out-of-range case.

## Timing
- Write latency is 1 edge: data written at edge N is readable by a read issued at edge N+1, and is returned at edge N+1 through forwarding if the read is issued at edge N.
- Read latency is 1 edge: the address is sampled at edge N and data is valid after edge N until the next enabled read.
- There is no handshake and no stall. The write port and both read ports all accept every cycle.
- Reset release: the first edge with rst_n high performs normal operation. No dead cycle is required.
- There is no combinational path from any input to rdata_a or rdata_b.

## Test plan
- Reset: RST_VAL=8'h5A, drive rst_n low between edges -> rdata_a and rdata_b become 8'h5A immediately, without a clock edge. Then read addresses 1..7 -> each returns 8'h5A; address 0 returns 8'h00.
- Write then read: write 8'h3C to r3; next cycle set raddr_a=3 and raddr_b=3 with both reads enabled -> both outputs equal 8'h3C one edge later.
- Forwarding: r4 holds 8'h11; in one cycle write 8'hEE to r4 and read r4 on port A -> rdata_a=8'hEE after that edge. Port B reading r5 in the same cycle is unaffected.
- Zero register: write 8'hFF to r0 while port A reads r0 -> rdata_a=8'h00. A read of r0 on the following cycle also returns 8'h00.
- Hold: after rdata_b=8'h3C, drop re_b, change raddr_b and write r3=8'h77 -> rdata_b stays 8'h3C. Raise re_b with raddr_b=3 -> rdata_b=8'h77.
- Mid-operation reset: assert rst_n low in the same cycle as a write of 8'h99 to r2 -> after release, a read of r2 returns RST_VAL, not 8'h99.
